gnn_load_multi: RTL and testbench
=================================

Name: gnn_load_multi

Overview:
- Parametrised next-generation DRAM-to-on-chip-buffer load unit for the GNN kernel.
- Decodes a 96-bit load instruction and issues one DRAM read request to the AXI read master.
- Accepts the returned beat stream with a valid/ready handshake and writes each beat to one of NUM_BUF on-chip buffers, selected by a one-hot group field.
- Adds over the previous load unit: a generic channel count, buffer address wrap, zero-length and illegal-instruction handling, early-tlast detection, a sticky error flag, and read_done gating before completion.

Parameters:
- LOAD_INST_LENGTH, 96, instruction width
- C_M_AXI_ADDR_WIDTH, 64, DRAM byte-address width
- C_M_AXI_DATA_WIDTH, 512, beat and buffer word width
- C_XFER_SIZE_WIDTH, 32, transfer byte-size width
- NUM_BUF, 5, buffer channels (1..6)
- BUF_ADDR_W, 11, buffer word-address width; depth is 2^BUF_ADDR_W

Ports:
- kernel_clk  in  1  clock
- kernel_rst  in  1  reset; synchronous, active-high
- ap_start  in  1  start request; sampled only in IDLE
- ap_done  out  1  one-cycle completion pulse
- ctrl_addr_offset  in  C_M_AXI_ADDR_WIDTH  DRAM base address
- ctrl_instruction  in  LOAD_INST_LENGTH  load instruction
- dram_xfer_start_addr  out  C_M_AXI_ADDR_WIDTH  offset + dram_start
- dram_xfer_size_in_bytes  out  C_XFER_SIZE_WIDTH  zero-extended dram_bytes
- read_start  out  1  one-cycle request pulse to the read master
- read_done  in  1  read master finished the request
- data_tvalid  in  1  stream beat valid
- data_tready  out  1  stream beat ready
- data_tlast  in  1  last beat of the stream
- data_tdata  in  C_M_AXI_DATA_WIDTH  stream beat data
- buf_wr_valid  out  NUM_BUF  one-hot per-buffer write strobe
- buf_wr_addr  out  BUF_ADDR_W  write address, shared by all buffers
- buf_wr_data  out  C_M_AXI_DATA_WIDTH  write data, shared by all buffers
- load_err  out  1  sticky error flag; cleared only by the next accepted ap_start

Behaviour:
- Instruction fields:
  - group = inst[NUM_BUF-1:0]
  - buf_start = inst[47:32]
  - buf_len = inst[63:48] (beats)
  - dram_start = inst[79:64]
  - dram_bytes = inst[95:80]
- Reset: state IDLE; every output 0; all internal counters and registers 0.
- Reset mid-operation aborts the transfer. No further writes occur, and an outstanding stream is not drained.
- FSM states: IDLE, ISSUE, STREAM, DRAIN, DONE.
- IDLE, ap_start=1 at cycle T:
  - Latch all fields and ctrl_addr_offset; clear load_err.
  - If group is not exactly one-hot, or group bits at or above NUM_BUF are set: set load_err and go to DONE (no read).
  - Else if buf_len==0: go to DONE (no read).
  - Else: go to ISSUE.
- ISSUE (T+1):
  - read_start=1 for exactly this cycle.
  - dram_xfer_* are stable from T+1 until the next accepted ap_start.
  - Next state is STREAM.
- STREAM:
  - data_tready=1; it is 0 in every other state.
  - A beat is accepted when data_tvalid && data_tready at cycle k.
  - At k+1 the buffer write is presented:
    - buf_wr_valid = group.
    - buf_wr_addr = (buf_start + count) mod 2^BUF_ADDR_W. The address wraps silently at the buffer top.
    - buf_wr_data = the accepted beat.
  - count increments per accepted beat.
  - buf_wr_valid is 0 in any cycle not following an accepted beat.
- Stream end conditions:
  - count reaches buf_len-1 at acceptance: go to DRAIN.
  - data_tlast accepted with count < buf_len-1: set load_err and go to DRAIN (early end).
  - Beats offered after the final beat are not accepted.
- read_done is captured in a sticky flag at any cycle from ISSUE onward.
- DRAIN: wait until the read_done flag is set, then go to DONE. The last buffer write is visible during the first DRAIN cycle.
- DONE: ap_done=1 for exactly one cycle, then IDLE.
- Minimum latency: with an N-beat stream and no stalls, where the last beat is accepted at cycle L and read_done is already seen, ap_done is asserted at L+2.
- ap_start outside IDLE is ignored.
- Address arithmetic is unsigned. count is 16 bits wide.

Optional Feature:
- Macro: GNN_LOAD_PERF_CNT_EN.
- When defined:
  - Add output perf_cycles (32 bits).
  - It resets to 0 on each accepted ap_start, increments every cycle while not in IDLE, and holds its value in IDLE. It saturates at all-ones.
- When undefined: the port and counter do not exist, and behaviour is otherwise identical.

Test Plan:
- Basic load:
  - Stimulus: group=0b00010, buf_start=0x010, buf_len=4, dram_start=0x100, offset=0x1000, dram_bytes=256, 4 back-to-back beats, read_done before the last beat.
  - Required: read_start at T+1; dram_xfer_start_addr=0x1100; buf_wr_valid=0b00010 at addresses 0x010..0x013 with matching data; ap_done at L+2; load_err=0.
- Wrap and backpressure:
  - Stimulus: buf_start=0x7FE, buf_len=4, data_tvalid toggled 1,0,1,0.
  - Required: addresses 0x7FE, 0x7FF, 0x000, 0x001; no writes in gap cycles.
- Illegal group:
  - Stimulus: group=0b00110.
  - Required: no read_start, no writes, load_err=1, ap_done at T+1.
- Zero length:
  - Stimulus: buf_len=0.
  - Required: no read_start, ap_done at T+1, load_err=0.
- Early tlast and late read_done:
  - Stimulus: buf_len=8, tlast on beat 3, read_done 5 cycles later.
  - Required: 3 writes; load_err=1; ap_done exactly 1 cycle after DRAIN sees read_done.
- Reset mid-stream:
  - Stimulus: assert kernel_rst after 2 of 6 beats.
  - Required: all outputs 0 the next cycle; a new instruction completes normally afterwards.

Source files
------------

// File: rtl/gnn_load_multi.sv
// ---------------------------------------------------------------------------
// gnn_load_multi
//
// DRAM-to-on-chip-buffer load unit for the GNN kernel. A 96-bit load
// instruction is decoded when ap_start is accepted. One DRAM read request is
// then issued to the AXI read master. The returned beat stream is written to
// one of NUM_BUF on-chip buffers, which is selected by a one-hot group field.
//
// Instruction fields:
//   [NUM_BUF-1:0] group (one-hot buffer select; bits [31:NUM_BUF] must be 0)
//   [47:32]       buf_start  first buffer word address
//   [63:48]       buf_len    number of beats to write
//   [79:64]       dram_start DRAM start, added to ctrl_addr_offset
//   [95:80]       dram_bytes transfer size in bytes
//
// Ports:
//   kernel_clk, kernel_rst      clock, synchronous active-high reset
//   ap_start / ap_done          start request (IDLE only) / one-cycle done pulse
//   ctrl_addr_offset            DRAM base address
//   ctrl_instruction            load instruction
//   dram_xfer_start_addr/size   read request parameters, stable after issue
//   read_start / read_done      request pulse to / completion from read master
//   data_tvalid/tready/tlast/tdata  returned beat stream
//   buf_wr_valid/addr/data      one-hot buffer write port (shared addr/data)
//   load_err                    sticky error, cleared by the next accepted start
//
// Optional build macro GNN_LOAD_PERF_CNT_EN adds a 32-bit output perf_cycles.
// perf_cycles counts the busy cycles of the latest load and saturates at
// all-ones.
// ---------------------------------------------------------------------------
module gnn_load_multi #(
  parameter int LOAD_INST_LENGTH   = 96,
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int NUM_BUF            = 5,
  parameter int BUF_ADDR_W         = 11
) (
  input  logic                          kernel_clk,
  input  logic                          kernel_rst,
  input  logic                          ap_start,
  output logic                          ap_done,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
  input  logic [LOAD_INST_LENGTH-1:0]   ctrl_instruction,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] dram_xfer_start_addr,
  output logic [C_XFER_SIZE_WIDTH-1:0]  dram_xfer_size_in_bytes,
  output logic                          read_start,
  input  logic                          read_done,
  input  logic                          data_tvalid,
  output logic                          data_tready,
  input  logic                          data_tlast,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] data_tdata,
  output logic [NUM_BUF-1:0]            buf_wr_valid,
  output logic [BUF_ADDR_W-1:0]         buf_wr_addr,
  output logic [C_M_AXI_DATA_WIDTH-1:0] buf_wr_data,
`ifdef GNN_LOAD_PERF_CNT_EN
  output logic [31:0]                   perf_cycles,
`endif
  output logic                          load_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  logic [NUM_BUF-1:0]            group_q, group_d;
  logic [15:0]                   buf_start_q, buf_start_d;
  logic [15:0]                   buf_len_q, buf_len_d;
  logic [15:0]                   count_q, count_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] xfer_addr_q, xfer_addr_d;
  logic [C_XFER_SIZE_WIDTH-1:0]  xfer_size_q, xfer_size_d;
  logic                          rd_done_q, rd_done_d;
  logic                          err_q, err_d;
  logic [NUM_BUF-1:0]            wr_valid_q, wr_valid_d;
  logic [BUF_ADDR_W-1:0]         wr_addr_q, wr_addr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  // Instruction decode of the group field. A legal group has exactly one bit
  // set, and no reserved bits above the channel count are set.
  logic [NUM_BUF-1:0] inst_group;
  logic               group_onehot;
  logic               group_hi_set;
  logic               group_ok;
  logic [15:0]        addr_sum;
  logic               last_beat;

  assign inst_group   = ctrl_instruction[NUM_BUF-1:0];
  assign group_onehot = (inst_group != '0) &&
                        ((inst_group & (inst_group - NUM_BUF'(1))) == '0);
  assign group_hi_set = |ctrl_instruction[31:NUM_BUF];
  assign group_ok     = group_onehot && !group_hi_set;

  // The buffer address wraps silently, because only the low BUF_ADDR_W bits
  // of the 16-bit sum are kept.
  assign addr_sum  = buf_start_q + count_q;
  assign last_beat = (count_q == (buf_len_q - 16'd1));

  // Next-state and datapath logic. Everything holds by default, and the
  // write strobe drops unless a beat is accepted in this cycle.
  always_comb begin
    state_d     = state_q;
    group_d     = group_q;
    buf_start_d = buf_start_q;
    buf_len_d   = buf_len_q;
    count_d     = count_q;
    xfer_addr_d = xfer_addr_q;
    xfer_size_d = xfer_size_q;
    rd_done_d   = rd_done_q;
    err_d       = err_q;
    wr_valid_d  = '0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    read_start  = 1'b0;
    data_tready = 1'b0;
    ap_done     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ap_start) begin
          group_d     = inst_group;
          buf_start_d = ctrl_instruction[47:32];
          buf_len_d   = ctrl_instruction[63:48];
          xfer_addr_d = ctrl_addr_offset +
                        C_M_AXI_ADDR_WIDTH'(ctrl_instruction[79:64]);
          xfer_size_d = C_XFER_SIZE_WIDTH'(ctrl_instruction[95:80]);
          count_d     = '0;
          rd_done_d   = 1'b0;
          err_d       = 1'b0;
          if (!group_ok) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (ctrl_instruction[63:48] == 16'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        read_start = 1'b1;
        if (read_done) rd_done_d = 1'b1;
        state_d = ST_STREAM;
      end

      ST_STREAM: begin
        data_tready = 1'b1;
        if (read_done) rd_done_d = 1'b1;
        if (data_tvalid) begin
          wr_valid_d = group_q;
          wr_addr_d  = addr_sum[BUF_ADDR_W-1:0];
          wr_data_d  = data_tdata;
          count_d    = count_q + 16'd1;
          // A tlast that arrives before the programmed length ends the
          // stream early and flags an error.
          if (last_beat) begin
            state_d = ST_DRAIN;
          end else if (data_tlast) begin
            err_d   = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end

      // The read master must report completion before ap_done. A read_done
      // seen in this cycle counts as well as the sticky flag.
      ST_DRAIN: begin
        if (read_done) rd_done_d = 1'b1;
        if (rd_done_q || read_done) state_d = ST_DONE;
      end

      ST_DONE: begin
        ap_done = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers. A reset aborts any transfer in flight.
  always_ff @(posedge kernel_clk) begin
    if (kernel_rst) begin
      state_q     <= ST_IDLE;
      group_q     <= '0;
      buf_start_q <= '0;
      buf_len_q   <= '0;
      count_q     <= '0;
      xfer_addr_q <= '0;
      xfer_size_q <= '0;
      rd_done_q   <= 1'b0;
      err_q       <= 1'b0;
      wr_valid_q  <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      group_q     <= group_d;
      buf_start_q <= buf_start_d;
      buf_len_q   <= buf_len_d;
      count_q     <= count_d;
      xfer_addr_q <= xfer_addr_d;
      xfer_size_q <= xfer_size_d;
      rd_done_q   <= rd_done_d;
      err_q       <= err_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

`ifdef GNN_LOAD_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  // Busy-cycle counter: it restarts on an accepted start, counts outside
  // IDLE, and holds at all-ones instead of wrapping.
  always_comb begin
    perf_d = perf_q;
    if (state_q == ST_IDLE) begin
      if (ap_start) perf_d = '0;
    end else if (perf_q != '1) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge kernel_clk) begin
    if (kernel_rst) perf_q <= '0;
    else            perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif

  assign dram_xfer_start_addr    = xfer_addr_q;
  assign dram_xfer_size_in_bytes = xfer_size_q;
  assign buf_wr_valid            = wr_valid_q;
  assign buf_wr_addr             = wr_addr_q;
  assign buf_wr_data             = wr_data_q;
  assign load_err                = err_q;

endmodule

// File: tb/tb_gnn_load_multi.sv
// ---------------------------------------------------------------------------
// tb_gnn_load_multi
//
// Testbench for gnn_load_multi. A table of load instructions, each with
// hand-computed expectations, is applied in a loop. Hand-written sequences
// follow for reset checks and for a reset in the middle of a stream.
// ---------------------------------------------------------------------------
module tb_gnn_load_multi;

  localparam int AW = 64;
  localparam int DW = 512;
  localparam int XW = 32;
  localparam int NB = 5;
  localparam int BW = 11;

  logic          kernel_clk = 1'b0;
  logic          kernel_rst;
  logic          ap_start;
  logic          ap_done;
  logic [AW-1:0] ctrl_addr_offset;
  logic [95:0]   ctrl_instruction;
  logic [AW-1:0] dram_xfer_start_addr;
  logic [XW-1:0] dram_xfer_size_in_bytes;
  logic          read_start;
  logic          read_done;
  logic          data_tvalid;
  logic          data_tready;
  logic          data_tlast;
  logic [DW-1:0] data_tdata;
  logic [NB-1:0] buf_wr_valid;
  logic [BW-1:0] buf_wr_addr;
  logic [DW-1:0] buf_wr_data;
  logic          load_err;
`ifdef GNN_LOAD_PERF_CNT_EN
  logic [31:0]   perf_cycles;
`endif

  gnn_load_multi #(
    .LOAD_INST_LENGTH  (96),
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(DW),
    .C_XFER_SIZE_WIDTH (XW),
    .NUM_BUF           (NB),
    .BUF_ADDR_W        (BW)
  ) dut (
    .kernel_clk             (kernel_clk),
    .kernel_rst             (kernel_rst),
    .ap_start               (ap_start),
    .ap_done                (ap_done),
    .ctrl_addr_offset       (ctrl_addr_offset),
    .ctrl_instruction       (ctrl_instruction),
    .dram_xfer_start_addr   (dram_xfer_start_addr),
    .dram_xfer_size_in_bytes(dram_xfer_size_in_bytes),
    .read_start             (read_start),
    .read_done              (read_done),
    .data_tvalid            (data_tvalid),
    .data_tready            (data_tready),
    .data_tlast             (data_tlast),
    .data_tdata             (data_tdata),
    .buf_wr_valid           (buf_wr_valid),
    .buf_wr_addr            (buf_wr_addr),
    .buf_wr_data            (buf_wr_data),
`ifdef GNN_LOAD_PERF_CNT_EN
    .perf_cycles            (perf_cycles),
`endif
    .load_err               (load_err)
  );

  // 10 ns clock period.
  always #5 kernel_clk = ~kernel_clk;

  // One load instruction with its hand-computed expectations. tl is the
  // 1-based beat that carries tlast (0 means no tlast). rdCyc is the cycle,
  // counted from the first cycle after the start edge, in which read_done
  // pulses.
  typedef struct {
    string       name;
    logic [31:0] grp;
    logic [15:0] bufStart;
    logic [15:0] bufLen;
    logic [15:0] dramStart;
    logic [15:0] dramBytes;
    logic [63:0] offset;
    bit          gaps;
    bit          holdStart;
    int          tl;
    int          nOffer;
    int          rdCyc;
    bit          expRead;
    bit          expErr;
    int          expWrites;
    logic [63:0] expDram;
  } vec_t;

  localparam int NVEC = 8;
  vec_t vecs [NVEC];

  int vecCount = 0;
  int errCount = 0;

  // Compares an actual value with its expected value and records the result.
  task automatic checkOutput(input string nm, input logic [DW-1:0] act,
                             input logic [DW-1:0] exp);
    vecCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [95:0] mkInst(input vec_t v);
    return {v.dramBytes, v.dramStart, v.bufLen, v.bufStart, v.grp};
  endfunction

  function automatic logic [DW-1:0] beatData(input int vi, input int k);
    logic [31:0] w;
    w = 32'hC0DE_0000 ^ 32'(vi * 256 + k);
    return {16{w}};
  endfunction

  // This is the cycle in which beat k is offered. While the unit streams,
  // that beat is also the one accepted in that cycle.
  function automatic int expAccept(input vec_t v, input int k);
    return v.gaps ? (2 + 2 * k) : (2 + k);
  endfunction

  // Checks that every DUT output is at its reset value.
  task automatic checkAllZero(input string tag);
    checkOutput({tag, ":ap_done"},     DW'(ap_done),                 '0);
    checkOutput({tag, ":read_start"},  DW'(read_start),              '0);
    checkOutput({tag, ":tready"},      DW'(data_tready),             '0);
    checkOutput({tag, ":wr_valid"},    DW'(buf_wr_valid),            '0);
    checkOutput({tag, ":wr_addr"},     DW'(buf_wr_addr),             '0);
    checkOutput({tag, ":wr_data"},     buf_wr_data,                  '0);
    checkOutput({tag, ":dram_addr"},   DW'(dram_xfer_start_addr),    '0);
    checkOutput({tag, ":dram_size"},   DW'(dram_xfer_size_in_bytes), '0);
    checkOutput({tag, ":load_err"},    DW'(load_err),                '0);
  endtask

  // Runs a single table vector. Inputs are driven 1 ns after each rising
  // edge, and outputs are sampled on the falling edge.
  task automatic applyStimulus(input int vi);
    vec_t          v;
    int            wIdx;
    int            doneCyc;
    int            driven;
    int            lastAcc;
    int            expDone;
    logic [9:0]    expAddr;
    v       = vecs[vi];
    wIdx    = 0;
    doneCyc = -1;
    driven  = 0;

    @(posedge kernel_clk); #1;
    ctrl_instruction = mkInst(v);
    ctrl_addr_offset = v.offset;
    ap_start         = 1'b1;
    @(posedge kernel_clk); #1;
    if (v.holdStart) ctrl_instruction = '1;
    else             ap_start = 1'b0;

    for (int cyc = 1; cyc <= 80; cyc++) begin
      read_done = (cyc == v.rdCyc);
      if (cyc >= 2 && driven < v.nOffer && (!v.gaps || (cyc % 2) == 0)) begin
        data_tvalid = 1'b1;
        data_tdata  = beatData(vi, driven);
        data_tlast  = (driven + 1 == v.tl);
        driven++;
      end else begin
        data_tvalid = 1'b0;
        data_tlast  = 1'b0;
        data_tdata  = '0;
      end

      @(negedge kernel_clk);
      if (cyc == 1) begin
        checkOutput({v.name, ":read_start"}, DW'(read_start), DW'(v.expRead));
        checkOutput({v.name, ":err_at_t1"}, DW'(load_err),
                    DW'(v.expErr && !v.expRead));
        if (v.expRead) begin
          checkOutput({v.name, ":dram_addr"}, DW'(dram_xfer_start_addr),
                      DW'(v.expDram));
          checkOutput({v.name, ":dram_size"}, DW'(dram_xfer_size_in_bytes),
                      DW'(v.dramBytes));
        end
      end else if (read_start) begin
        checkOutput({v.name, ":extra_read_start"}, DW'(read_start), '0);
      end

      if (wIdx < v.expWrites && cyc == expAccept(v, wIdx) + 1) begin
        expAddr = 10'(0);
        checkOutput({v.name, ":wr_valid"}, DW'(buf_wr_valid),
                    DW'(v.grp[NB-1:0]));
        checkOutput({v.name, ":wr_addr"}, DW'(buf_wr_addr),
                    DW'((32'(v.bufStart) + 32'(wIdx)) & 32'h7FF));
        checkOutput({v.name, ":wr_data"}, buf_wr_data, beatData(vi, wIdx));
        wIdx++;
      end else if (buf_wr_valid != '0) begin
        checkOutput({v.name, ":stray_write"}, DW'(buf_wr_valid), '0);
      end

      if (ap_done) begin
        doneCyc = cyc;
        break;
      end
      @(posedge kernel_clk); #1;
    end

    lastAcc = (v.expWrites > 0) ? expAccept(v, v.expWrites - 1) : 0;
    if (!v.expRead)                        expDone = 1;
    else if (lastAcc + 2 >= v.rdCyc + 1)   expDone = lastAcc + 2;
    else                                   expDone = v.rdCyc + 1;

    checkOutput({v.name, ":done_cycle"}, DW'(doneCyc), DW'(expDone));
    checkOutput({v.name, ":load_err"}, DW'(load_err), DW'(v.expErr));
    checkOutput({v.name, ":writes"}, DW'(wIdx), DW'(v.expWrites));

    @(posedge kernel_clk); #1;
    ap_start    = 1'b0;
    data_tvalid = 1'b0;
    data_tlast  = 1'b0;
    read_done   = 1'b0;
    @(negedge kernel_clk);
    checkOutput({v.name, ":done_one_cycle"}, DW'(ap_done), '0);
    checkOutput({v.name, ":err_sticky"}, DW'(load_err), DW'(v.expErr));
  endtask

  // This sequence asserts reset after two of six beats. Every output must be
  // cleared, and the unit must stay idle afterwards.
  task automatic resetMidStream();
    @(posedge kernel_clk); #1;
    ctrl_instruction = {16'd384, 16'h0000, 16'd6, 16'h0040, 32'h0000_0004};
    ctrl_addr_offset = 64'h4000;
    ap_start         = 1'b1;
    @(posedge kernel_clk); #1;
    ap_start = 1'b0;
    @(posedge kernel_clk); #1;
    data_tvalid = 1'b1;
    data_tdata  = beatData(20, 0);
    @(posedge kernel_clk); #1;
    data_tdata  = beatData(20, 1);
    @(posedge kernel_clk); #1;
    data_tdata  = beatData(20, 2);
    kernel_rst  = 1'b1;
    @(negedge kernel_clk);
    checkOutput("rst_mid:pre_wr_valid", DW'(buf_wr_valid), DW'(5'b00100));
    checkOutput("rst_mid:pre_wr_addr", DW'(buf_wr_addr), DW'(11'h041));
    @(posedge kernel_clk); #1;
    kernel_rst = 1'b0;
    @(negedge kernel_clk);
    checkAllZero("rst_mid");
    @(posedge kernel_clk); #1;
    @(negedge kernel_clk);
    checkOutput("rst_mid:no_drain_wr", DW'(buf_wr_valid), '0);
    checkOutput("rst_mid:no_drain_tready", DW'(data_tready), '0);
    data_tvalid = 1'b0;
    data_tdata  = '0;
  endtask

  initial begin
    vecs[0] = '{"basic",   32'h02, 16'h010, 16'd4, 16'h100, 16'd256, 64'h1000,
                1'b0, 1'b0, 4, 4, 3, 1'b1, 1'b0, 4, 64'h1100};
    vecs[1] = '{"wrap",    32'h01, 16'h7FE, 16'd4, 16'h020, 16'h100, 64'h2000,
                1'b1, 1'b1, 4, 4, 2, 1'b1, 1'b0, 4, 64'h2020};
    vecs[2] = '{"illegal", 32'h06, 16'h000, 16'd4, 16'h010, 16'd64, 64'h3000,
                1'b0, 1'b0, 4, 0, 0, 1'b0, 1'b1, 0, 64'h0};
    vecs[3] = '{"zerolen", 32'h04, 16'h000, 16'd0, 16'h010, 16'd64, 64'h3000,
                1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 64'h0};
    vecs[4] = '{"early",   32'h10, 16'h100, 16'd8, 16'h040, 16'd512, 64'h8000,
                1'b0, 1'b0, 3, 3, 9, 1'b1, 1'b1, 3, 64'h8040};
    vecs[5] = '{"extra",   32'h08, 16'h020, 16'd2, 16'h000, 16'd128, 64'h500,
                1'b0, 1'b0, 2, 5, 1, 1'b1, 1'b0, 2, 64'h500};
    vecs[6] = '{"hibit",   32'h22, 16'h000, 16'd4, 16'h000, 16'd64, 64'h0,
                1'b0, 1'b0, 4, 0, 0, 1'b0, 1'b1, 0, 64'h0};
    vecs[7] = '{"single",  32'h01, 16'h3FF, 16'd1, 16'hFFFF, 16'd64, 64'h1,
                1'b0, 1'b0, 0, 1, 2, 1'b1, 1'b0, 1, 64'h10000};

    kernel_rst       = 1'b1;
    ap_start         = 1'b0;
    ctrl_addr_offset = '0;
    ctrl_instruction = '0;
    read_done        = 1'b0;
    data_tvalid      = 1'b0;
    data_tlast       = 1'b0;
    data_tdata       = '0;
    repeat (2) @(posedge kernel_clk);
    @(negedge kernel_clk);
    checkAllZero("reset");
    #1;
    kernel_rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(i);
    end

    resetMidStream();
    applyStimulus(0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
